// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard/forwarding controller.
// Provides the "no forward" select code, forward-select width helper
// and a saturating increment used by the performance counters.
package hazard_pkg;

    // Forward select value meaning "read the register file".
    localparam int FWD_NONE = 0;

    // Width needed to encode 0..n forward sources.
    function automatic int fs_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(
        input logic [63:0] v,
        input int          w
    );
        logic [63:0] top;
        top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= top) ? top : v + 64'd1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_stall_ctrl.sv
// Mult/div busy tracking, flush/stall priority and perf counters.
// Ports: hz_stall/md_start/md_use/is_link/br_taken in; pipeline
// enables, flushes, stall, md_busy and saturating counters out.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             is_link,
    input  logic             br_taken,
    input  logic             md_start,
    input  logic             md_use,
    output logic             en_if,
    output logic             en_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             stall,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_W = $clog2(MD_LAT + 1);

    logic [MD_W-1:0]  md_cnt_q;
    logic [MD_W-1:0]  md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             md_stall;
    logic             raw_stall;
    logic             md_acc;

    assign md_busy   = (md_cnt_q != '0);
    assign md_stall  = md_busy & (md_use | md_start);
    assign raw_stall = hz_stall | md_stall;

    // A taken branch discards the ID instruction, so it cannot stall.
    assign stall     = raw_stall & ~br_taken;
    assign md_acc    = md_start & ~raw_stall & ~br_taken;

    assign en_if     = ~stall;
    assign en_id     = ~stall;
    assign flush_ex  = br_taken | stall;
    assign flush_id  = br_taken | (~stall & is_link);

    // The in-flight mult/div is older than any branch: keep counting.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_acc) begin
            md_cnt_d = MD_W'(MD_LAT);
        end else if (md_busy) begin
            md_cnt_d = md_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
            if (stall) begin
                stall_cnt_q <= CNT_W'(sat_inc(64'(stall_cnt_q), CNT_W));
            end
            if (flush_id) begin
                flush_cnt_q <= CNT_W'(sat_inc(64'(flush_cnt_q), CNT_W));
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// RAW hazard detection and operand forwarding for the ID stage.
// Ports: ID sources, downstream stage writes in; forward selects,
// pipeline enables/flushes, stall, md_busy and perf counters out.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter  int REG_AW     = 5,
    parameter  int FWD_STAGES = 2,
    parameter  int LOAD_LAT   = 1,
    parameter  int MD_LAT     = 4,
    parameter  int CNT_W      = 32,
    localparam int FS_W       = fs_width(FWD_STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_AW-1:0]            rs_addr,
    input  logic [REG_AW-1:0]            rt_addr,
    input  logic                         rs_used,
    input  logic                         rt_used,
    input  logic                         is_store,
    input  logic                         is_link,
    input  logic                         br_taken,
    input  logic                         md_start,
    input  logic                         md_use,
    input  logic [FWD_STAGES*REG_AW-1:0] wr_addr,
    input  logic [FWD_STAGES-1:0]        wr_en,
    input  logic [FWD_STAGES-1:0]        wr_is_load,
    output logic [FS_W-1:0]              fwd_a,
    output logic [FS_W-1:0]              fwd_b,
    output logic                         fwd_m,
    output logic                         en_if,
    output logic                         en_id,
    output logic                         flush_id,
    output logic                         flush_ex,
    output logic                         stall,
    output logic                         md_busy,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt
);

    logic [FWD_STAGES-1:0] hit_a;
    logic [FWD_STAGES-1:0] hit_b;
    logic                  hz_stall;

    for (genvar k = 0; k < FWD_STAGES; k++) begin : g_stage
        logic [REG_AW-1:0] dst;
        assign dst = wr_addr[k*REG_AW +: REG_AW];
        assign hit_a[k] = rs_used && (rs_addr != '0)
                        && wr_en[k] && (dst == rs_addr);
        assign hit_b[k] = rt_used && (rt_addr != '0)
                        && wr_en[k] && (dst == rt_addr);
    end

    always_comb begin
        int   win_a;
        int   win_b;
        logic ld_a;
        logic ld_b;
        win_a    = FWD_NONE;
        win_b    = FWD_NONE;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        fwd_a    = '0;
        fwd_b    = '0;
        fwd_m    = 1'b0;
        hz_stall = 1'b0;
        // Walk oldest to youngest so the youngest match is kept last.
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (hit_a[k-1]) begin
                win_a = k;
                ld_a  = wr_is_load[k-1];
            end
            if (hit_b[k-1]) begin
                win_b = k;
                ld_b  = wr_is_load[k-1];
            end
        end
        if (win_a != FWD_NONE) begin
            if (!ld_a || win_a > LOAD_LAT) begin
                fwd_a = FS_W'(win_a);
            end else begin
                hz_stall = 1'b1;
            end
        end
        if (win_b != FWD_NONE) begin
            if (!ld_b || win_b > LOAD_LAT) begin
                fwd_b = FS_W'(win_b);
            end else if (is_store && win_b == LOAD_LAT) begin
                // Store data is needed late, after the load returns.
                fwd_m = 1'b1;
            end else begin
                hz_stall = 1'b1;
            end
        end
    end

    hazard_stall_ctrl #(
        .MD_LAT (MD_LAT),
        .CNT_W  (CNT_W)
    ) u_stall_ctrl (
        .clk       (clk),
        .rst       (rst),
        .hz_stall  (hz_stall),
        .is_link   (is_link),
        .br_taken  (br_taken),
        .md_start  (md_start),
        .md_use    (md_use),
        .en_if     (en_if),
        .en_id     (en_id),
        .flush_id  (flush_id),
        .flush_ex  (flush_ex),
        .stall     (stall),
        .md_busy   (md_busy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed self-checking bench for hazard_ctrl_unit.
// Default instance plus a 3-stage, LOAD_LAT=2, 3-bit counter instance.
module tb_hazard_ctrl_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance
    logic [4:0]  rs_addr, rt_addr;
    logic        rs_used, rt_used, is_store, is_link;
    logic        br_taken, md_start, md_use;
    logic [9:0]  wr_addr;
    logic [1:0]  wr_en, wr_is_load;
    logic [1:0]  fwd_a, fwd_b;
    logic        fwd_m, en_if, en_id, flush_id, flush_ex;
    logic        stall, md_busy;
    logic [31:0] stall_cnt, flush_cnt;

    // 3-stage instance
    logic [4:0]  c_rs_addr, c_rt_addr;
    logic        c_rs_used, c_rt_used, c_is_store;
    logic [14:0] c_wr_addr;
    logic [2:0]  c_wr_en, c_wr_is_load;
    logic [1:0]  c_fwd_a, c_fwd_b;
    logic        c_fwd_m, c_en_if, c_en_id, c_flush_id, c_flush_ex;
    logic        c_stall, c_md_busy;
    logic [2:0]  c_stall_cnt, c_flush_cnt;

    hazard_ctrl_unit dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_used    (rs_used),
        .rt_used    (rt_used),
        .is_store   (is_store),
        .is_link    (is_link),
        .br_taken   (br_taken),
        .md_start   (md_start),
        .md_use     (md_use),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .wr_is_load (wr_is_load),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .fwd_m      (fwd_m),
        .en_if      (en_if),
        .en_id      (en_id),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .stall      (stall),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    hazard_ctrl_unit #(
        .FWD_STAGES (3),
        .LOAD_LAT   (2),
        .CNT_W      (3)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (c_rs_addr),
        .rt_addr    (c_rt_addr),
        .rs_used    (c_rs_used),
        .rt_used    (c_rt_used),
        .is_store   (c_is_store),
        .is_link    (1'b0),
        .br_taken   (1'b0),
        .md_start   (1'b0),
        .md_use     (1'b0),
        .wr_addr    (c_wr_addr),
        .wr_en      (c_wr_en),
        .wr_is_load (c_wr_is_load),
        .fwd_a      (c_fwd_a),
        .fwd_b      (c_fwd_b),
        .fwd_m      (c_fwd_m),
        .en_if      (c_en_if),
        .en_id      (c_en_id),
        .flush_id   (c_flush_id),
        .flush_ex   (c_flush_ex),
        .stall      (c_stall),
        .md_busy    (c_md_busy),
        .stall_cnt  (c_stall_cnt),
        .flush_cnt  (c_flush_cnt)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled
    // 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
        is_store = 0; is_link = 0; br_taken = 0;
        md_start = 0; md_use = 0;
        wr_addr = 0; wr_en = 0; wr_is_load = 0;
    endtask

    task automatic c_idle();
        c_rs_addr = 0; c_rt_addr = 0; c_rs_used = 0;
        c_rt_used = 0; c_is_store = 0;
        c_wr_addr = 0; c_wr_en = 0; c_wr_is_load = 0;
    endtask

    initial begin
        idle();
        c_idle();
        rst = 1;
        tick();
        tick();
        rst = 0;
        #1;
        // reset state
        chk("rst_en_if", en_if, 1);
        chk("rst_en_id", en_id, 1);
        chk("rst_flush_id", flush_id, 0);
        chk("rst_flush_ex", flush_ex, 0);
        chk("rst_stall", stall, 0);
        chk("rst_md_busy", md_busy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // rs matches non-load in stage 2
        rs_used = 1; rs_addr = 5;
        wr_addr = {5'd5, 5'd0}; wr_en = 2'b10;
        #1;
        chk("s2_fwd_a", fwd_a, 2);
        chk("s2_stall", stall, 0);
        tick();
        chk("s2_stall_cnt", stall_cnt, 0);

        // rt matches load in stage 1, not a store
        idle();
        rt_used = 1; rt_addr = 7;
        wr_addr = {5'd0, 5'd7}; wr_en = 2'b01; wr_is_load = 2'b01;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_en_if", en_if, 0);
        chk("lu_en_id", en_id, 0);
        chk("lu_flush_ex", flush_ex, 1);
        chk("lu_flush_id", flush_id, 0);
        chk("lu_fwd_b", fwd_b, 0);
        tick();
        chk("lu_stall_cnt", stall_cnt, 1);

        // same but a store: late store-data forward
        is_store = 1;
        #1;
        chk("st_fwd_m", fwd_m, 1);
        chk("st_fwd_b", fwd_b, 0);
        chk("st_stall", stall, 0);
        tick();
        chk("st_stall_cnt", stall_cnt, 1);

        // youngest of two matches wins
        idle();
        rs_used = 1; rs_addr = 9;
        wr_addr = {5'd9, 5'd9}; wr_en = 2'b11;
        #1;
        chk("yng_fwd_a", fwd_a, 1);
        // r0 never forwards
        rs_addr = 0; wr_addr = {5'd0, 5'd0};
        #1;
        chk("r0_fwd_a", fwd_a, 0);
        // unused source never forwards
        rs_addr = 9; wr_addr = {5'd9, 5'd9}; rs_used = 0;
        #1;
        chk("unused_fwd_a", fwd_a, 0);

        // branch beats load-use stall and link
        idle();
        rt_used = 1; rt_addr = 3;
        wr_addr = {5'd0, 5'd3}; wr_en = 2'b01; wr_is_load = 2'b01;
        br_taken = 1; is_link = 1;
        #1;
        chk("br_flush_id", flush_id, 1);
        chk("br_flush_ex", flush_ex, 1);
        chk("br_stall", stall, 0);
        chk("br_en_if", en_if, 1);
        tick();
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);

        // link alone
        idle();
        is_link = 1;
        #1;
        chk("lnk_flush_id", flush_id, 1);
        chk("lnk_flush_ex", flush_ex, 0);
        tick();
        chk("lnk_flush_cnt", flush_cnt, 2);

        // mult/div: accepted, then md_use stalls exactly 4 cycles
        idle();
        md_start = 1;
        #1;
        chk("md_start_stall", stall, 0);
        tick();
        md_start = 0; md_use = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("md_busy_stall", stall, 1);
            chk("md_busy_flag", md_busy, 1);
            tick();
        end
        chk("md_rel_stall", stall, 0);
        chk("md_rel_busy", md_busy, 0);
        chk("md_stall_cnt", stall_cnt, 5);

        // reset mid mult/div aborts the count
        idle();
        md_start = 1;
        tick();
        md_start = 0; md_use = 1;
        tick();
        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("mdrst_busy", md_busy, 0);
        chk("mdrst_stall", stall, 0);
        chk("mdrst_stall_cnt", stall_cnt, 0);

        // md_start with taken branch is not accepted
        idle();
        md_start = 1; br_taken = 1;
        tick();
        idle();
        #1;
        chk("mdbr_busy", md_busy, 0);

        // branch while busy: counter keeps running
        md_start = 1;
        tick();
        md_start = 0; br_taken = 1;
        tick();
        br_taken = 0;
        #1;
        chk("brbusy_busy", md_busy, 1);
        tick();
        tick();
        tick();
        chk("brbusy_done", md_busy, 0);

        // 3-stage instance: load in stage 2 stalls rs
        idle();
        c_rs_used = 1; c_rs_addr = 4;
        c_wr_addr = {5'd0, 5'd4, 5'd0};
        c_wr_en = 3'b010; c_wr_is_load = 3'b010;
        #1;
        chk("c3_s2_stall", c_stall, 1);
        chk("c3_s2_fwd_a", c_fwd_a, 0);
        // load in stage 3 forwards
        c_wr_addr = {5'd4, 5'd0, 5'd0};
        c_wr_en = 3'b100; c_wr_is_load = 3'b100;
        #1;
        chk("c3_s3_fwd_a", c_fwd_a, 3);
        chk("c3_s3_stall", c_stall, 0);

        // store data from load at stage LOAD_LAT=2 forwards late
        c_idle();
        c_rt_used = 1; c_rt_addr = 6; c_is_store = 1;
        c_wr_addr = {5'd0, 5'd6, 5'd0};
        c_wr_en = 3'b010; c_wr_is_load = 3'b010;
        #1;
        chk("c3_st_fwd_m", c_fwd_m, 1);
        chk("c3_st_stall", c_stall, 0);
        // store data from load at stage 1 must stall
        c_wr_addr = {5'd0, 5'd0, 5'd6};
        c_wr_en = 3'b001; c_wr_is_load = 3'b001;
        #1;
        chk("c3_st1_stall", c_stall, 1);
        chk("c3_st1_fwd_m", c_fwd_m, 0);

        // stall 10 cycles: 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        chk("c3_sat_cnt", c_stall_cnt, 7);
        tick();
        chk("c3_sat_hold", c_stall_cnt, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
